// File: rtl/lpddr5_pkg.sv
// Shared command/state encodings and lane helpers for the LPDDR5 DRAM responder.
package lpddr5_pkg;
  localparam int BL     = 8;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 7;

  typedef enum logic [1:0] {CMD_NOP, CMD_ACT, CMD_CAS, CMD_PRE} cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_RD_WAIT, S_RD_BURST, S_WR_WAIT, S_WR_BURST, S_WR_COMMIT
  } state_e;

  function automatic cmd_e decode_cmd(input logic cs, input logic ras, input logic cas);
    if (!cs) return CMD_NOP;
    case ({ras, cas})
      2'b10:   return CMD_ACT;
      2'b01:   return CMD_CAS;
      2'b11:   return CMD_PRE;
      default: return CMD_NOP;
    endcase
  endfunction

  // Lane format: [17] reserved 0, [16] even parity over [15:0], [15:0] data.
  function automatic logic [17:0] lane_pack(input logic [15:0] d);
    return {1'b0, ^d, d};
  endfunction
endpackage

// File: rtl/lpddr5_data_ram.sv
// 128 x 256-bit line store, one shared address, registered read port.
module lpddr5_data_ram
  import lpddr5_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [2**ADDR_W];

  // No reset and no init: contents persist across rst and are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/lpddr5_dram_responder.sv
// Single-bank LPDDR5-style responder: ACT/RD/WR/PRE decode, tRCD/CL/CWL timing, BL8 bursts.
module lpddr5_dram_responder
  import lpddr5_pkg::*;
#(
  parameter int TRCD = 4,
  parameter int CL   = 6,
  parameter int CWL  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CS0,
  input  logic        RAS,
  input  logic        CAS,
  input  logic [14:0] ADDR15,
  input  logic [17:0] DATA18A_in,
  input  logic [17:0] DATA18B_in,
  output logic [17:0] DATA18A_out,
  output logic [17:0] DATA18B_out,
  output logic        dq_oe,
  output logic        row_open,
  output logic        busy,
  output logic        cmd_err,
  output logic        par_err
);
  // tRCD register holds the value the counter will show next cycle, so a
  // CAS exactly TRCD cycles after ACT sees zero.
  localparam logic [3:0] TRCD_LD   = 4'(TRCD - 1);
  localparam logic [3:0] CL_LD     = 4'(CL - 2);
  localparam logic [3:0] CWL_LD    = (CWL > 1) ? 4'(CWL - 2) : 4'd0;
  localparam logic [2:0] LAST_BEAT = 3'(BL - 1);

  state_e state_q, state_d;
  cmd_e   cmd;
  logic   is_wr, cas_ok, illegal, rd_issue;
  logic [3:0] trcd_q, lat_q;
  logic [2:0] beat_q, row_q;
  logic [3:0] col_q;
  logic [BL-1:0][31:0] wline_q;
  logic [BL-1:0][31:0] rd_beats;
  logic [LINE_W-1:0]   ram_rdata;
  logic [ADDR_W-1:0]   ram_addr;
  logic ram_we, ram_re;
  logic unused_bits;

  assign cmd   = decode_cmd(CS0, RAS, CAS);
  assign is_wr = ADDR15[14];
  assign unused_bits = ^{ADDR15[13:4], DATA18A_in[17], DATA18B_in[17]};

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    cas_ok  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd == CMD_ACT)      state_d = S_ACTIVE;
        else if (cmd != CMD_NOP) illegal = 1'b1;
      end
      S_ACTIVE: begin
        case (cmd)
          CMD_PRE: state_d = S_IDLE;
          CMD_ACT: illegal = 1'b1;
          CMD_CAS: begin
            if (trcd_q != 4'd0) illegal = 1'b1;
            else begin
              cas_ok = 1'b1;
              if (!is_wr)        state_d = S_RD_WAIT;
              else if (CWL == 1) state_d = S_WR_BURST;
              else               state_d = S_WR_WAIT;
            end
          end
          default: ;
        endcase
      end
      S_RD_WAIT: begin
        illegal = (cmd != CMD_NOP);
        if (lat_q == 4'd0) state_d = S_RD_BURST;
      end
      S_RD_BURST: begin
        illegal = (cmd != CMD_NOP);
        if (beat_q == LAST_BEAT) state_d = S_ACTIVE;
      end
      S_WR_WAIT: begin
        illegal = (cmd != CMD_NOP);
        if (lat_q == 4'd0) state_d = S_WR_BURST;
      end
      S_WR_BURST: begin
        illegal = (cmd != CMD_NOP);
        if (beat_q == LAST_BEAT) state_d = S_WR_COMMIT;
      end
      S_WR_COMMIT: begin
        illegal = (cmd != CMD_NOP);
        state_d = S_ACTIVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_issue = cas_ok && !is_wr;
  assign ram_re   = rd_issue && !rst;
  assign ram_we   = (state_q == S_WR_COMMIT) && !rst;
  assign ram_addr = (state_q == S_WR_COMMIT) ? {row_q, col_q} : {row_q, ADDR15[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      trcd_q  <= 4'd0;
      lat_q   <= 4'd0;
      beat_q  <= 3'd0;
      row_q   <= 3'd0;
      col_q   <= 4'd0;
      cmd_err <= 1'b0;
      par_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (illegal) cmd_err <= 1'b1;

      if (state_q == S_IDLE && cmd == CMD_ACT) begin
        row_q  <= ADDR15[2:0];
        trcd_q <= TRCD_LD;
      end else if (trcd_q != 4'd0) begin
        trcd_q <= trcd_q - 4'd1;
      end

      if (cas_ok) begin
        col_q <= ADDR15[3:0];
        lat_q <= is_wr ? CWL_LD : CL_LD;
      end else if (lat_q != 4'd0) begin
        lat_q <= lat_q - 4'd1;
      end

      // Wraps to 0 after the eighth beat, ready for the next burst.
      if (state_q == S_RD_BURST || state_q == S_WR_BURST) beat_q <= beat_q + 3'd1;

      if (state_q == S_WR_BURST) begin
        wline_q[beat_q] <= {DATA18B_in[15:0], DATA18A_in[15:0]};
        if ((DATA18A_in[16] != ^DATA18A_in[15:0]) || (DATA18B_in[16] != ^DATA18B_in[15:0]))
          par_err <= 1'b1;
      end
    end
  end

  lpddr5_data_ram u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(wline_q),
    .rdata(ram_rdata)
  );

  assign rd_beats    = ram_rdata;
  assign dq_oe       = (state_q == S_RD_BURST);
  assign DATA18A_out = dq_oe ? lane_pack(rd_beats[beat_q][15:0])  : 18'd0;
  assign DATA18B_out = dq_oe ? lane_pack(rd_beats[beat_q][31:16]) : 18'd0;
  assign row_open    = (state_q != S_IDLE);
  assign busy        = (state_q != S_IDLE) && (state_q != S_ACTIVE);
endmodule
